// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo -- single-clock first-in/first-out buffer with registered read data
//
// Parameters
//   FIFO_WIDTH  data word width in bits (default 16)
//   FIFO_DEPTH  number of storage entries, legal range 4..256 (default 8)
//
// Ports
//   clk          sole clock, all state updates on its rising edge
//   rst_n        asynchronous active-low reset
//   wr_en        write request, sampled at rising clk
//   rd_en        read request, sampled at rising clk
//   data_in      write data, sampled together with wr_en
//   data_out     registered read data (one cycle after an accepted read)
//   wr_ack       registered: the previous cycle's write was accepted
//   overflow     registered: the previous cycle's write was rejected (full)
//   underflow    registered: the previous cycle's read was rejected (empty)
//   full, empty, almostfull, almostempty
//                combinational occupancy flags decoded from the count
//
// Handshake: there is no back-pressure on the request lines. A write is
// accepted in a cycle where wr_en=1 and full=0; a read is accepted in a cycle
// where rd_en=1 and empty=0. Requests outside those conditions are dropped
// and reported one cycle later on overflow/underflow. wr_ack and data_out
// report the outcome of accepted requests one cycle later.
//
// Build option
//   SYNC_FIFO_STICKY_ERR_EN  when defined, overflow and underflow latch at 1
//                            once set and clear only on reset; when undefined
//                            they are single-cycle pulses.
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [FIFO_WIDTH-1:0] data_in,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_AFULL  = CNT_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = '0;

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;

    logic do_wr;
    logic do_rd;

    // Occupancy flags come straight from the count so they reflect the
    // current state in the same cycle.
    assign full        = (count == CNT_FULL);
    assign empty       = (count == CNT_ZERO);
    assign almostfull  = (count == CNT_AFULL);
    assign almostempty = (count == CNT_ONE);

    // Gating with full/empty means a simultaneous request on an empty FIFO
    // only writes, and on a full FIFO only reads.
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    // Storage is not reset: stale entries are unreachable once the pointers
    // and count are cleared.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                // Explicit wrap so non-power-of-two depths work.
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out  <= '0;
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (do_rd) begin
                data_out <= mem[rd_ptr];
            end
            wr_ack <= do_wr;
`ifdef SYNC_FIFO_STICKY_ERR_EN
            overflow  <= overflow  || (wr_en && full);
            underflow <= underflow || (rd_en && empty);
`else
            overflow  <= wr_en && full;
            underflow <= rd_en && empty;
`endif
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo -- directed/randomised bench for sync_fifo (16 bits x 8 entries)
// Expected read data comes from a queue filled as writes are driven; flags and
// error outputs come from a small occupancy model kept by the bench.
// -----------------------------------------------------------------------------
module tb_sync_fifo;

    localparam int W = 16;
    localparam int D = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         wr_en;
    logic         rd_en;
    logic [W-1:0] data_in;
    logic [W-1:0] data_out;
    logic         wr_ack;
    logic         overflow;
    logic         underflow;
    logic         full;
    logic         empty;
    logic         almostfull;
    logic         almostempty;

    sync_fifo #(.FIFO_WIDTH(W), .FIFO_DEPTH(D)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .data_in     (data_in),
        .data_out    (data_out),
        .wr_ack      (wr_ack),
        .overflow    (overflow),
        .underflow   (underflow),
        .full        (full),
        .empty       (empty),
        .almostfull  (almostfull),
        .almostempty (almostempty)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int           m_count;
    logic [W-1:0] exp_dout;
    logic         exp_ovf;
    logic         exp_udf;
    logic         exp_wack;
    int           checks;
    int           errors;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".data_out"},    32'(data_out),    32'(exp_dout));
        chk({tag, ".wr_ack"},      32'(wr_ack),      32'(exp_wack));
        chk({tag, ".overflow"},    32'(overflow),    32'(exp_ovf));
        chk({tag, ".underflow"},   32'(underflow),   32'(exp_udf));
        chk({tag, ".full"},        32'(full),        32'(m_count == D));
        chk({tag, ".empty"},       32'(empty),       32'(m_count == 0));
        chk({tag, ".almostfull"},  32'(almostfull),  32'(m_count == D - 1));
        chk({tag, ".almostempty"}, 32'(almostempty), 32'(m_count == 1));
    endtask

    // ---------------- driver ----------------
    // Drives one cycle of requests, updates the model, then checks after the
    // edge (1 time unit past it, away from the active edge).
    task automatic do_op(input string tag, input logic w, input logic r, input logic [W-1:0] d);
        logic acc_w;
        logic acc_r;
        acc_w = w && (m_count < D);
        acc_r = r && (m_count > 0);
        if (acc_r) exp_dout = exp_q.pop_front();
        if (acc_w) exp_q.push_back(d);
        m_count = m_count + int'(acc_w) - int'(acc_r);
        exp_wack = acc_w;
`ifdef SYNC_FIFO_STICKY_ERR_EN
        exp_ovf = exp_ovf || (w && !acc_w);
        exp_udf = exp_udf || (r && !acc_r);
`else
        exp_ovf = w && !acc_w;
        exp_udf = r && !acc_r;
`endif
        wr_en   = w;
        rd_en   = r;
        data_in = d;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        data_in = '0;
        chk_all(tag);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_count  = 0;
        exp_dout = '0;
        exp_ovf  = 1'b0;
        exp_udf  = 1'b0;
        exp_wack = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        data_in = '0;
        model_reset();

        // Reset state, checked while reset is held and after release
        #23;
        chk_all("reset_held");
        rst_n = 1'b1;
        #10;
        chk_all("reset_released");

        // Fill: 0x0001..0x0008, almostfull after 7th, full after 8th
        for (int i = 1; i <= D; i++) begin
            do_op("fill", 1'b1, 1'b0, W'(i));
        end
        chk("fill_full", 32'(full), 32'd1);

        // Write when full: overflow for one cycle, nothing stored
        do_op("ovf_write", 1'b1, 1'b0, 16'hDEAD);
        do_op("ovf_idle", 1'b0, 1'b0, '0);

        // Drain in order, then one read on empty
        for (int i = 1; i <= D; i++) begin
            do_op("drain", 1'b0, 1'b1, '0);
        end
        chk("drain_last", 32'(data_out), 32'h0008);
        do_op("udf_read", 1'b0, 1'b1, '0);
        chk("udf_hold", 32'(data_out), 32'h0008);
        do_op("udf_idle", 1'b0, 1'b0, '0);

        // Simultaneous read/write on empty: write only
        do_op("rw_empty", 1'b1, 1'b1, 16'h1111);
        for (int i = 0; i < D - 1; i++) begin
            do_op("refill", 1'b1, 1'b0, W'(16'h2000 + i));
        end
        // Simultaneous read/write on full: read only
        do_op("rw_full", 1'b1, 1'b1, 16'h2222);
        chk("rw_full_af", 32'(almostfull), 32'd1);
        while (m_count > 0) begin
            do_op("drain2", 1'b0, 1'b1, '0);
        end

        // 20 writes interleaved with random reads, crossing the pointer wrap
        for (int i = 0; i < 20; i++) begin
            do_op("mix", 1'b1, 1'($urandom_range(0, 1)), W'($urandom_range(0, 16'hFFFF)));
            if ($urandom_range(0, 2) == 0) begin
                do_op("mix_rd", 1'b0, 1'b1, '0);
            end
        end
        while (m_count > 0) begin
            do_op("mix_drain", 1'b0, 1'b1, '0);
        end

        // Asynchronous reset at count 5, observed before the next edge
        for (int i = 0; i < 5; i++) begin
            do_op("pre_rst", 1'b1, 1'b0, W'(16'h5A00 + i));
        end
`ifdef SYNC_FIFO_STICKY_ERR_EN
        chk("sticky_ovf_before_rst", 32'(overflow), 32'd1);
`endif
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_all("async_rst");
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_all("post_rst");

        // Normal operation resumes after reset
        do_op("resume_wr", 1'b1, 1'b0, 16'hBEEF);
        do_op("resume_rd", 1'b0, 1'b1, '0);
        chk("resume_data", 32'(data_out), 32'hBEEF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 The block SHALL provide parameter FIFO_WIDTH, default 16, meaning data word width in bits.
REQ-002 The block SHALL provide parameter FIFO_DEPTH, default 8, meaning number of storage entries (legal range 4..256).
REQ-003 The block SHALL provide port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 The block SHALL provide port rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-005 The block SHALL provide port wr_en  input  1  write request, sampled at rising clk.
REQ-006 The block SHALL provide port rd_en  input  1  read request, sampled at rising clk.
REQ-007 The block SHALL provide port data_in  input  FIFO_WIDTH  write data, sampled with wr_en.
REQ-008 The block SHALL provide port data_out  output  FIFO_WIDTH  registered read data.
REQ-009 The block SHALL provide port wr_ack  output  1  registered; previous-cycle write accepted.
REQ-010 The block SHALL provide port overflow  output  1  registered; write rejected because full.
REQ-011 The block SHALL provide port underflow  output  1  registered; read rejected because empty.
REQ-012 The block SHALL provide ports full, empty, almostfull, almostempty  output  1 each  combinational occupancy flags.

Function
REQ-013 The block SHALL keep an occupancy count of width clog2(FIFO_DEPTH)+1, a write pointer and a read pointer, each pointer wrapping from FIFO_DEPTH-1 to 0.
REQ-014 The block SHALL decode flags from count: full = (count==FIFO_DEPTH), empty = (count==0), almostfull = (count==FIFO_DEPTH-1), almostempty = (count==1).
REQ-015 The block SHALL, on wr_en && !full, store data_in at write pointer, advance pointer, and assert wr_ack for exactly the next cycle.
REQ-016 The block SHALL, on wr_en && full, discard data_in, leave state unchanged, hold wr_ack 0, and assert overflow the next cycle.
REQ-017 The block SHALL, on rd_en && !empty, load data_out with the entry at read pointer (1-cycle latency) and advance the read pointer.
REQ-018 The block SHALL, on rd_en && empty, hold data_out, leave state unchanged, and assert underflow the next cycle.
REQ-019 The block SHALL, on wr_en && rd_en with 0<count<FIFO_DEPTH, perform both operations and leave count unchanged.
REQ-020 The block SHALL, on wr_en && rd_en when empty, perform only the write (count 0->1, wr_ack=1, underflow=1).
REQ-021 The block SHALL, on wr_en && rd_en when full, perform only the read (count DEPTH->DEPTH-1, overflow=1, wr_ack=0).
REQ-022 The block SHALL hold data_out unchanged in any cycle without an accepted read.
REQ-023 The block SHALL deassert wr_ack, and (without the macro of REQ-029) overflow and underflow, in any cycle not meeting their set condition.

Reset
REQ-024 The block SHALL, while rst_n=0, immediately force count, both pointers, data_out, wr_ack, overflow and underflow to 0.
REQ-025 The block SHALL present empty=1, full=0, almostfull=0, almostempty=0 during and after reset.
REQ-026 The block SHALL treat reset mid-operation as discarding all stored entries; memory contents need not be cleared.
REQ-027 The block SHALL resume normal operation on the first rising clk after rst_n deasserts.

Configuration
REQ-028 The block SHALL support macro SYNC_FIFO_STICKY_ERR_EN.
REQ-029 The block SHALL, with SYNC_FIFO_STICKY_ERR_EN defined, hold overflow and underflow at 1 once set until rst_n asserts.
REQ-030 The block SHALL, without SYNC_FIFO_STICKY_ERR_EN, drive overflow and underflow as single-cycle pulses per REQ-016/018/023.

Verification (FIFO_DEPTH=8, FIFO_WIDTH=16)
REQ-031 Bench SHALL cover: reset, 8 writes 0x0001..0x0008 -> wr_ack=1 each, almostfull after 7th, full after 8th.
REQ-032 Bench SHALL cover: 9th write 0xDEAD when full -> overflow=1 one cycle, wr_ack=0, count stays 8.
REQ-033 Bench SHALL cover: 8 reads after REQ-031 -> data_out 0x0001..0x0008 in order, almostempty at count 1, then empty; extra read -> underflow=1, data_out stays 0x0008.
REQ-034 Bench SHALL cover: simultaneous wr_en/rd_en when empty -> count 1, wr_ack=1, underflow=1; when full -> count 7, overflow=1.
REQ-035 Bench SHALL cover: 20 writes interleaved with reads (pointer wrap) -> read order matches write order, no flag errors.
REQ-036 Bench SHALL cover: rst_n=0 asynchronously at count 5 -> empty=1, data_out=0 before next clk edge; with SYNC_FIFO_STICKY_ERR_EN, overflow stays 1 until this reset.
